// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low hex keypad one row at a time,
// debounces presses and releases on a slow scan tick, and shifts each
// accepted 4-bit key code into a 16-bit value register.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 625,
    parameter int unsigned DEBOUNCE_TICKS = 40
) (
    input  logic        clk5,
    input  logic        reset,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] value,
    output logic        busy
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_TICKS - 1);

    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;
    localparam logic [1:0] RELEASE  = 2'd3;

    logic [3:0]       col_m;
    logic [3:0]       col_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [1:0]       row_idx;
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [DEB_W-1:0] deb_cnt;
    logic [3:0]       cand_code;
    logic             any_low;
    logic [1:0]       col_idx;
    logic [3:0]       code;

    assign tick = (div_cnt == DIV_LAST);
    assign row  = ~(4'b0001 << row_idx);

    // Two-flop synchroniser for the asynchronous column lines.
    always_ff @(posedge clk5) begin
        if (reset) begin
            col_m <= 4'b1111;
            col_s <= 4'b1111;
        end else begin
            col_m <= col;
            col_s <= col_m;
        end
    end

    // Free-running scan tick divider.
    always_ff @(posedge clk5) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Column priority decode: lowest low column wins.
    always_comb begin
        col_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col_s[i]) begin
                col_idx = 2'(i);
            end
        end
        any_low = (col_s != 4'b1111);
        code    = {row_idx, col_idx};
    end

    // FSM next state; transitions only happen on scan ticks.
    always_comb begin
        state_next = state;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (any_low) state_next = DEBOUNCE;
                end
                DEBOUNCE: begin
                    // all-high decodes to column 0, so any_low must gate the compare
                    if (!(any_low && code == cand_code)) begin
                        state_next = SCAN;
                    end else if (deb_cnt == DEB_LAST) begin
                        state_next = HELD;
                    end
                end
                HELD: begin
                    if (!any_low) state_next = RELEASE;
                end
                RELEASE: begin
                    if (any_low) begin
                        state_next = HELD;
                    end else if (deb_cnt == DEB_LAST) begin
                        state_next = SCAN;
                    end
                end
                default: state_next = SCAN;
            endcase
        end
    end

    // FSM state, row scan, debounce counter and accepted-key datapath.
    always_ff @(posedge clk5) begin
        if (reset) begin
            state     <= SCAN;
            busy      <= 1'b0;
            row_idx   <= 2'd0;
            deb_cnt   <= '0;
            cand_code <= 4'h0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            value     <= 16'h0000;
        end else begin
            state     <= state_next;
            busy      <= (state_next != SCAN);
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (any_low) begin
                            cand_code <= code;
                            deb_cnt   <= '0;
                        end else begin
                            row_idx <= row_idx + 2'd1;
                        end
                    end
                    DEBOUNCE: begin
                        if (any_low && code == cand_code) begin
                            if (deb_cnt == DEB_LAST) begin
                                key_valid <= 1'b1;
                                key_code  <= cand_code;
                                value     <= {value[11:0], cand_code};
                            end else begin
                                deb_cnt <= deb_cnt + DEB_W'(1);
                            end
                        end
                    end
                    HELD: begin
                        if (!any_low) deb_cnt <= '0;
                    end
                    RELEASE: begin
                        if (!any_low && deb_cnt != DEB_LAST) begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: a keypad model drives the columns from the
// DUT row drive and a set of pressed keys; a scoreboard holds the expected
// code/value for each press and a monitor checks every key_valid pulse.
module tb_keypad_scanner;

    logic        clk5 = 1'b0;
    logic        reset;
    logic [3:0]  col;
    logic [3:0]  row;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] value;
    logic        busy;

    logic [15:0] pressed = 16'h0000;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] val;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_TICKS (3)
    ) dut (
        .clk5      (clk5),
        .reset     (reset),
        .col       (col),
        .row       (row),
        .key_valid (key_valid),
        .key_code  (key_code),
        .value     (value),
        .busy      (busy)
    );

    always #5 clk5 = ~clk5;

    always @(posedge clk5) cyc <= cyc + 1;

    // Keypad model: key r*4+c pulls column c low while row r is driven low.
    always_comb begin
        col = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no event within 200 cycles, required one", name);
    endtask

    // Monitor: every key_valid pulse must match the oldest expected press.
    always @(negedge clk5) begin
        if (key_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_key_valid: got pulse with code %0h, required none",
                         key_code);
            end else begin
                mon_e = sb.pop_front();
                check("key_code", int'(key_code), int'(mon_e.code));
                check("value", int'(value), int'(mon_e.val));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk5);
        reset = 1'b1;
        repeat (2) @(posedge clk5);
        @(negedge clk5);
        reset = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk5);
            if (busy === lvl) begin
                ok = 1'b1;
                return;
            end
        end
        timeout(lvl ? "busy_rise" : "busy_fall");
    endtask

    task automatic wait_kv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk5);
            if (key_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        timeout("key_valid");
    endtask

    task automatic push_exp(input logic [3:0] c, input logic [15:0] v);
        exp_t e;
        e.code = c;
        e.val  = v;
        sb.push_back(e);
    endtask

    // Clean press: detect, debounce, accept, then a fully debounced release.
    task automatic press_key(input logic [3:0] c, input logic [15:0] v);
        int t_det;
        bit ok;
        push_exp(c, v);
        pressed = 16'h0001 << c;
        wait_busy(1'b1, ok);
        t_det = cyc;
        wait_kv(ok);
        if (ok) check("latency", cyc - t_det, 12);
        pressed = 16'h0000;
        wait_busy(1'b0, ok);
        repeat (4) @(negedge clk5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] row_seq [4];
        logic [3:0] row_held;
        bit ok;
        row_seq[0] = 4'b1110;
        row_seq[1] = 4'b1101;
        row_seq[2] = 4'b1011;
        row_seq[3] = 4'b0111;
        reset = 1'b1;

        // Reset state and idle row scanning.
        do_reset();
        check("rst_row", int'(row), 4'b1110);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_key_code", int'(key_code), 0);
        check("rst_value", int'(value), 0);
        check("rst_busy", int'(busy), 0);
        for (int i = 1; i <= 8; i++) begin
            repeat (4) @(posedge clk5);
            @(negedge clk5);
            check("idle_row", int'(row), int'(row_seq[i % 4]));
        end
        check("idle_value", int'(value), 0);

        // Single key: row 1, column 2.
        press_key(4'h6, 16'h0006);

        // Bouncing press: each short contact aborts the debounce.
        for (int i = 0; i < 5; i++) begin
            pressed = 16'h0001 << 9;
            wait_busy(1'b1, ok);
            pressed = 16'h0000;
            wait_busy(1'b0, ok);
        end
        press_key(4'h9, 16'h0069);

        // Five keys shift through the value register.
        do_reset();
        press_key(4'h1, 16'h0001);
        press_key(4'h2, 16'h0012);
        press_key(4'h3, 16'h0123);
        press_key(4'h4, 16'h1234);
        press_key(4'h5, 16'h2345);

        // Held key with a second column and a short release glitch.
        push_exp(4'hA, 16'h345A);
        pressed = 16'h0001 << 10;
        wait_kv(ok);
        row_held = row;
        check("held_row", int'(row_held), 4'b1011);
        pressed = pressed | (16'h0001 << 11);
        repeat (8) @(negedge clk5);
        check("held_busy", int'(busy), 1);
        check("held_row_frozen", int'(row), int'(row_held));
        pressed = 16'h0001 << 10;
        repeat (4) @(negedge clk5);
        pressed = 16'h0000;
        repeat (8) @(negedge clk5);
        pressed = 16'h0001 << 10;
        repeat (8) @(negedge clk5);
        check("glitch_busy", int'(busy), 1);
        check("glitch_row_frozen", int'(row), int'(row_held));
        pressed = 16'h0000;
        wait_busy(1'b0, ok);
        repeat (4) @(negedge clk5);

        // Reset in DEBOUNCE with the counter at 2 (row 3 key).
        pressed = 16'h0001 << 14;
        wait_busy(1'b1, ok);
        repeat (8) @(posedge clk5);
        #1;
        reset = 1'b1;
        pressed = 16'h0000;
        @(posedge clk5);
        @(negedge clk5);
        check("mid_rst_key_valid", int'(key_valid), 0);
        check("mid_rst_row", int'(row), 4'b1110);
        check("mid_rst_value", int'(value), 0);
        check("mid_rst_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (40) @(negedge clk5);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
